// File: rtl/key_expansion_ctrl.sv
// AES-128 key-schedule controller.
// Takes a cipher key through a start/busy handshake and derives round keys
// 1..10, one per clock. All 11 round keys are held in a register file that
// the round datapath reads through a registered port.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       expansion request, sampled only while busy=0
//   key_in      cipher key, [127:96]=w0 .. [31:0]=w3
//   busy        expansion in progress
//   key_ready   all 11 round keys valid
//   rk_rd_addr  round-key index 0..10 (11..15 read as zero)
//   rk_rd_data  round key for the previous cycle's rk_rd_addr
module key_expansion_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             key_ready,
  input  logic [3:0]       rk_rd_addr,
  output logic [KEY_W-1:0] rk_rd_data
);

  localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;
  localparam int unsigned CNT_W    = 4;

  // Only AES-128 is supported; anything else stops elaboration.
  if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_bad_params
    $error("key_expansion_ctrl supports only NUM_ROUNDS=10, KEY_W=128");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               busy_q, busy_d;
  logic               key_ready_q, key_ready_d;
  logic [KEY_W-1:0]   rk_rd_data_q, rk_rd_data_d;
  logic [KEY_W-1:0]   rk_q [0:NUM_KEYS-1];
  logic [KEY_W-1:0]   rk_d [0:NUM_KEYS-1];

  logic [CNT_W-1:0]   prev_idx;
  logic [KEY_W-1:0]   prev_key;
  logic [31:0]        rot_word;
  logic [31:0]        sub_word;
  logic [31:0]        temp_word;
  logic [31:0]        w0_n, w1_n, w2_n, w3_n;
  logic [KEY_W-1:0]   next_key;
  logic [7:0]         rcon_xtime;

  // Source key for the round currently being generated.
  always_comb begin
    prev_idx = cnt_q - CNT_W'(1);
    prev_key = rk_q[prev_idx];
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    byte_substitution u_sbox (
      .in_byte  (rot_word[8*i +: 8]),
      .out_byte (sub_word[8*i +: 8])
    );
  end

  // Round-key derivation: each new word chains off the previous new word.
  always_comb begin
    temp_word = sub_word ^ {rcon_q, 24'h0};
    w0_n      = prev_key[127:96] ^ temp_word;
    w1_n      = prev_key[95:64]  ^ w0_n;
    w2_n      = prev_key[63:32]  ^ w1_n;
    w3_n      = prev_key[31:0]   ^ w2_n;
    next_key  = {w0_n, w1_n, w2_n, w3_n};
  end

  // GF(2^8) doubling keeps rcon correct past 0x80 (gives 1B, 36).
  assign rcon_xtime = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcon_d      = rcon_q;
    busy_d      = busy_q;
    key_ready_d = key_ready_q;
    rk_d        = rk_q;

    // Read port runs in every state; no bypass of same-edge writes.
    if (rk_rd_addr <= CNT_W'(NUM_ROUNDS)) begin
      rk_rd_data_d = rk_q[rk_rd_addr];
    end else begin
      rk_rd_data_d = '0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          rk_d[0]     = key_in;
          cnt_d       = CNT_W'(1);
          rcon_d      = 8'h01;
          busy_d      = 1'b1;
          key_ready_d = 1'b0;
          state_d     = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        rk_d[cnt_q] = next_key;
        rcon_d      = rcon_xtime;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_ROUNDS)) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          key_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rcon_q       <= 8'h01;
      busy_q       <= 1'b0;
      key_ready_q  <= 1'b0;
      rk_rd_data_q <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcon_q       <= rcon_d;
      busy_q       <= busy_d;
      key_ready_q  <= key_ready_d;
      rk_rd_data_q <= rk_rd_data_d;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        rk_q[i] <= rk_d[i];
      end
    end
  end

  assign busy       = busy_q;
  assign key_ready  = key_ready_q;
  assign rk_rd_data = rk_rd_data_q;

endmodule

// AES forward S-box, pure lookup.
//   in_byte   byte to substitute
//   out_byte  S-box output
module byte_substitution (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench for key_expansion_ctrl: FIPS-197 key schedule,
// rcon wrap, start-while-busy, mid-expansion reset, re-expansion and
// out-of-range reads.
module tb_key_expansion_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_ready;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;

  int unsigned passed;
  int unsigned total;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
    string        name;
  } rd_vec_t;

  rd_vec_t fips_tbl [7];
  rd_vec_t seq_tbl  [4];

  key_expansion_ctrl #(
    .NUM_ROUNDS (10),
    .KEY_W      (128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .key_ready  (key_ready),
    .rk_rd_addr (rk_rd_addr),
    .rk_rd_data (rk_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply address, let the registered port capture it, sample after the edge.
  task automatic read_rk(input logic [3:0] addr, output logic [127:0] data);
    @(negedge clk);
    rk_rd_addr = addr;
    @(posedge clk);
    #1;
    data = rk_rd_data;
  endtask

  // Issue a one-cycle start and wait for key_ready with a cycle budget.
  // edges: clock edges after the start edge until key_ready was seen.
  task automatic expand(input logic [127:0] key, input bit inject,
                        output int busy_cnt, output int edges,
                        output logic kr_first, output logic busy_first);
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    @(posedge clk);
    #1;
    busy_cnt   = busy ? 1 : 0;
    kr_first   = key_ready;
    busy_first = busy;
    edges      = 0;
    while (!key_ready && edges < 40) begin
      @(negedge clk);
      start  = inject && (edges == 3);
      key_in = start ? 128'h0 : '1;
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cnt++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_table(input rd_vec_t tbl [], input string tag);
    logic [127:0] d;
    for (int i = 0; i < tbl.size(); i++) begin
      read_rk(tbl[i].addr, d);
      check({tag, "_", tbl[i].name}, d, tbl[i].exp);
    end
  endtask

  initial begin
    logic [127:0] d;
    int           bc;
    int           ed;
    logic         kr0;
    logic         b0;

    passed = 0;
    total  = 0;

    fips_tbl[0] = '{4'd0,  FIPS_KEY,                                "rk0"};
    fips_tbl[1] = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "rk1"};
    fips_tbl[2] = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, "rk2"};
    fips_tbl[3] = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, "rk9"};
    fips_tbl[4] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rk10"};
    fips_tbl[5] = '{4'd11, 128'h0,                                "addr11"};
    fips_tbl[6] = '{4'd15, 128'h0,                                "addr15"};

    seq_tbl[0] = '{4'd0,  SEQ_KEY,                                 "rk0"};
    seq_tbl[1] = '{4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5,  "rk10"};
    seq_tbl[2] = '{4'd11, 128'h0,                                 "addr11"};
    seq_tbl[3] = '{4'd15, 128'h0,                                 "addr15"};

    rst        = 1'b1;
    start      = 1'b0;
    key_in     = '0;
    rk_rd_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",      128'(busy),      128'(0));
    check("reset_key_ready", 128'(key_ready), 128'(0));
    check("reset_rd_data",   rk_rd_data,      128'h0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 expansion with a start pulse injected mid-expansion.
    expand(FIPS_KEY, 1'b1, bc, ed, kr0, b0);
    check("fips_busy_first",   128'(b0),  128'(1));
    check("fips_kr_first",     128'(kr0), 128'(0));
    check("fips_busy_cycles",  128'(bc),  128'(10));
    check("fips_ready_edges",  128'(ed),  128'(10));
    check("fips_busy_done",    128'(busy), 128'(0));
    run_table(fips_tbl, "fips");

    // Reset during expansion discards everything.
    @(negedge clk);
    key_in = FIPS_KEY;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy",      128'(busy),      128'(0));
    check("midrst_key_ready", 128'(key_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    read_rk(4'd0, d);
    check("midrst_rk0", d, 128'h0);
    read_rk(4'd10, d);
    check("midrst_rk10", d, 128'h0);

    // Fresh expansion after the abort.
    expand(FIPS_KEY, 1'b0, bc, ed, kr0, b0);
    check("post_rst_edges", 128'(ed), 128'(10));
    read_rk(4'd10, d);
    check("post_rst_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Re-expand from DONE with a different key.
    expand(SEQ_KEY, 1'b0, bc, ed, kr0, b0);
    check("reexp_kr_drop",   128'(kr0), 128'(0));
    check("reexp_busy_cyc",  128'(bc),  128'(10));
    check("reexp_edges",     128'(ed),  128'(10));
    check("reexp_key_ready", 128'(key_ready), 128'(1));
    run_table(seq_tbl, "seq");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
